// File: rtl/bitwise_logic_unit_if.sv
// Handshake and data bundle for bitwise_logic_unit; the reduction flags only
// exist when BITWISE_REDUCE_EN is defined.
interface bitwise_logic_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [3:0]       ctrl_opcode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             out_valid;
  logic             out_ready;
`ifdef BITWISE_REDUCE_EN
  logic             data_isZero;
  logic             data_parity;
`endif

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_opcode,
    output in_valid,
    output out_ready,
`ifdef BITWISE_REDUCE_EN
    input  data_isZero,
    input  data_parity,
`endif
    input  in_ready,
    input  data_result,
    input  data_exception,
    input  out_valid
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_opcode,
    input  in_valid,
    input  out_ready,
`ifdef BITWISE_REDUCE_EN
    output data_isZero,
    output data_parity,
`endif
    output in_ready,
    output data_result,
    output data_exception,
    output out_valid
  );
endinterface

// File: rtl/bitwise_logic_unit.sv
// Two-stage valid/ready pipelined bitwise logic unit (8 ops, opcodes 8-15 raise
// an exception). Define BITWISE_REDUCE_EN to add registered isZero/parity flags.
module bitwise_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  bitwise_logic_unit_if.slave  bus
);
  logic             s1_v;
  logic             s2_v;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s2_result;
  logic             s2_exception;
  logic [WIDTH-1:0] next_result;
  logic             next_exception;
`ifdef BITWISE_REDUCE_EN
  logic             s2_is_zero;
  logic             s2_parity;
`endif

  // A stage may take new contents when it is empty or its occupant moves on.
  assign s2_load      = !s2_v || bus.out_ready;
  assign s1_load      = !s1_v || s2_load;
  assign bus.in_ready = s1_load;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_op <= '0;
    end else if (s1_load) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.data_operandA;
        s1_b  <= bus.data_operandB;
        s1_op <= bus.ctrl_opcode;
      end
    end
  end

  always_comb begin
    next_result    = '0;
    next_exception = s1_op[3];
    if (!s1_op[3]) begin
      case (s1_op[2:0])
        3'd0: next_result = s1_a & s1_b;
        3'd1: next_result = s1_a | s1_b;
        3'd2: next_result = s1_a ^ s1_b;
        3'd3: next_result = ~(s1_a | s1_b);
        3'd4: next_result = ~(s1_a & s1_b);
        3'd5: next_result = ~(s1_a ^ s1_b);
        3'd6: next_result = s1_a & ~s1_b;
        3'd7: next_result = s1_a | ~s1_b;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_v         <= 1'b0;
      s2_result    <= '0;
      s2_exception <= 1'b0;
`ifdef BITWISE_REDUCE_EN
      s2_is_zero   <= 1'b0;
      s2_parity    <= 1'b0;
`endif
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_result    <= next_result;
        s2_exception <= next_exception;
`ifdef BITWISE_REDUCE_EN
        s2_is_zero   <= ~|next_result;
        s2_parity    <= ^next_result;
`endif
      end
    end
  end

  assign bus.out_valid      = s2_v;
  assign bus.data_result    = s2_result;
  assign bus.data_exception = s2_exception;
`ifdef BITWISE_REDUCE_EN
  assign bus.data_isZero    = s2_is_zero;
  assign bus.data_parity    = s2_parity;
`endif
endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit (WIDTH=32); inputs change
// and outputs are sampled on the falling clock edge.
module tb_bitwise_logic_unit;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset_n;
  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;
  logic [31:0] exp_vec [8] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h000F000F,
                               32'hFF0FFF0F, 32'h00FF00FF, 32'hF000F000, 32'hF0FFF0FF};

  bitwise_logic_unit_if #(.WIDTH(WIDTH)) bus ();

  bitwise_logic_unit #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b);
    bus.in_valid      = valid;
    bus.ctrl_opcode   = op;
    bus.data_operandA = a;
    bus.data_operandB = b;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    apply_stimulus(1'b0, 4'd0, 32'h0, 32'h0);
    #1;
    check_output("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check_output("rst_result", bus.data_result, 32'h0);
    check_output("rst_exception", {31'b0, bus.data_exception}, 32'h0);
    check_output("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
`ifdef BITWISE_REDUCE_EN
    check_output("rst_is_zero", {31'b0, bus.data_isZero}, 32'h0);
    check_output("rst_parity", {31'b0, bus.data_parity}, 32'h0);
`endif
    tick();
    tick();
    reset_n = 1'b1;
    check_output("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

    $display("[TB] all eight opcodes back to back");
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        check_output($sformatf("op%0d_valid", i - 2), {31'b0, bus.out_valid}, 32'h1);
        check_output($sformatf("op%0d_result", i - 2), bus.data_result, exp_vec[i - 2]);
        check_output($sformatf("op%0d_exception", i - 2), {31'b0, bus.data_exception}, 32'h0);
      end
      if (i < 8) begin
        apply_stimulus(1'b1, 4'(i), 32'hF0F0F0F0, 32'h0FF00FF0);
        check_output($sformatf("op%0d_in_ready", i), {31'b0, bus.in_ready}, 32'h1);
      end else begin
        apply_stimulus(1'b0, 4'd0, 32'h0, 32'h0);
      end
      tick();
    end
    check_output("ops_drained", {31'b0, bus.out_valid}, 32'h0);

    $display("[TB] illegal opcode then legal opcode");
    apply_stimulus(1'b1, 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    apply_stimulus(1'b1, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'h0, 32'h0);
    check_output("illegal_valid", {31'b0, bus.out_valid}, 32'h1);
    check_output("illegal_result", bus.data_result, 32'h0);
    check_output("illegal_exception", {31'b0, bus.data_exception}, 32'h1);
    tick();
    check_output("legal_result", bus.data_result, 32'hFFFFFFFF);
    check_output("legal_exception", {31'b0, bus.data_exception}, 32'h0);
    tick();
    check_output("illegal_drained", {31'b0, bus.out_valid}, 32'h0);

    $display("[TB] backpressure with three offered transactions");
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 4'd2, 32'h12345678, 32'hFFFF0000);
    check_output("bp_ready_t1", {31'b0, bus.in_ready}, 32'h1);
    tick();
    apply_stimulus(1'b1, 4'd6, 32'hFFFFFFFF, 32'h000000FF);
    check_output("bp_ready_t2", {31'b0, bus.in_ready}, 32'h1);
    tick();
    apply_stimulus(1'b1, 4'd3, 32'h00000001, 32'h00000002);
    check_output("bp_ready_t3", {31'b0, bus.in_ready}, 32'h0);
    check_output("bp_valid", {31'b0, bus.out_valid}, 32'h1);
    check_output("bp_result_t1", bus.data_result, 32'hEDCB5678);
    tick();
    check_output("bp_still_blocked", {31'b0, bus.in_ready}, 32'h0);
    check_output("bp_hold_t1", bus.data_result, 32'hEDCB5678);
    tick();
    check_output("bp_hold2_t1", bus.data_result, 32'hEDCB5678);
    bus.out_ready = 1'b1;
    #1;
    check_output("bp_release_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'h0, 32'h0);
    check_output("bp_result_t2", bus.data_result, 32'hFFFFFF00);
    tick();
    check_output("bp_result_t3", bus.data_result, 32'hFFFFFFFC);
    check_output("bp_valid_t3", {31'b0, bus.out_valid}, 32'h1);
    tick();
    check_output("bp_drained", {31'b0, bus.out_valid}, 32'h0);

    $display("[TB] reset with two transactions in flight");
    apply_stimulus(1'b1, 4'd4, 32'hFFFF0000, 32'hFF00FF00);
    tick();
    apply_stimulus(1'b1, 4'd5, 32'h0000FFFF, 32'h00FF00FF);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'h0, 32'h0);
    check_output("inflight_result", bus.data_result, 32'h00FFFFFF);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check_output("async_rst_result", bus.data_result, 32'h0);
    check_output("async_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    reset_n = 1'b1;
    check_output("stale_0", {31'b0, bus.out_valid}, 32'h0);
    tick();
    check_output("stale_1", {31'b0, bus.out_valid}, 32'h0);
    tick();
    check_output("stale_2", {31'b0, bus.out_valid}, 32'h0);
    apply_stimulus(1'b1, 4'd7, 32'h0, 32'h0);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'h0, 32'h0);
    tick();
    check_output("post_rst_valid", {31'b0, bus.out_valid}, 32'h1);
    check_output("post_rst_result", bus.data_result, 32'hFFFFFFFF);
    tick();

`ifdef BITWISE_REDUCE_EN
    $display("[TB] reduction flags");
    apply_stimulus(1'b1, 4'd2, 32'h12345678, 32'h12345678);
    tick();
    apply_stimulus(1'b1, 4'd1, 32'h00000007, 32'h00000000);
    tick();
    apply_stimulus(1'b0, 4'd0, 32'h0, 32'h0);
    check_output("red_xor_result", bus.data_result, 32'h0);
    check_output("red_xor_is_zero", {31'b0, bus.data_isZero}, 32'h1);
    check_output("red_xor_parity", {31'b0, bus.data_parity}, 32'h0);
    tick();
    check_output("red_or_result", bus.data_result, 32'h7);
    check_output("red_or_is_zero", {31'b0, bus.data_isZero}, 32'h0);
    check_output("red_or_parity", {31'b0, bus.data_parity}, 32'h1);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 1 to 64.
REQ-002 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port data_operandA, input, WIDTH: operand A.
REQ-005 Port data_operandB, input, WIDTH: operand B.
REQ-006 Port ctrl_opcode, input, 4: operation select.
REQ-007 Port in_valid, input, 1: operands and opcode are valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts a transaction this cycle.
REQ-009 Port data_result, output, WIDTH: result of the transaction at the head of the pipeline.
REQ-010 Port data_exception, output, 1: the head transaction used an illegal opcode.
REQ-011 Port out_valid, output, 1: data_result and data_exception are valid.
REQ-012 Port out_ready, input, 1: consumer takes the head result this cycle.

Function
REQ-013 The block SHALL accept a transaction on a clock edge where in_valid and in_ready are both 1.
REQ-014 The block SHALL deliver a result on a clock edge where out_valid and out_ready are both 1.
REQ-015 Opcodes 0 to 7 SHALL select, in order: A&B, A|B, A^B, ~(A|B), ~(A&B), ~(A^B), A&~B, A|~B.
REQ-016 Opcodes 8 to 15 SHALL produce data_result = 0 with data_exception = 1; legal opcodes SHALL produce data_exception = 0.
REQ-017 The block SHALL be a two-stage pipeline: S1 registers the operands and opcode; S2 registers the result and exception.
REQ-018 Each stage SHALL hold a valid bit: s1_v and s2_v.
REQ-019 S2 SHALL load when s2_load = !s2_v or out_ready.
REQ-020 S1 SHALL load when s1_load = !s1_v or s2_load.
REQ-021 in_ready SHALL equal s1_load, combinationally, with no dependence on in_valid.
REQ-022 out_valid SHALL equal s2_v, and data_result and data_exception SHALL be driven directly from the S2 registers.
REQ-023 Latency SHALL be exactly 2 cycles from acceptance to out_valid with an unstalled consumer.
REQ-024 Throughput SHALL be 1 transaction per cycle when out_ready is held at 1.
REQ-025 While out_valid = 1 and out_ready = 0, the S2 outputs SHALL remain stable.
REQ-026 While S1 is stalled behind S2, the S1 contents SHALL remain stable.
REQ-027 With a full pipeline, an edge with out_ready = 1 and in_valid = 1 SHALL drain S2, advance S1 into S2 and accept new data into S1, all on the same edge.
REQ-028 When a stage loads with no valid input, its valid bit SHALL clear; data bits are don't-care when the valid bit is 0.
REQ-029 Results SHALL be returned strictly in acceptance order; no transaction is dropped or duplicated.

Reset
REQ-030 Asserting reset_n = 0 SHALL immediately clear s1_v and s2_v, forcing out_valid = 0, data_result = 0 and data_exception = 0.
REQ-031 in_ready SHALL read 1 during and after reset.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight transactions.
REQ-033 After reset_n deasserts, the first accepting edge is the first clock edge with in_valid = 1.

Configuration
REQ-034 With macro BITWISE_REDUCE_EN defined, the block SHALL add output data_isZero (1 bit) and output data_parity (1 bit).
REQ-035 data_isZero SHALL be the NOR-reduction of the S2 result, and data_parity SHALL be the XOR-reduction of the S2 result.
REQ-036 Both added outputs SHALL be registered in S2 alongside the result, 0 on reset, and follow the same stall rules.
REQ-037 With BITWISE_REDUCE_EN undefined, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=32)
REQ-038 Directed scenario: A=0xF0F0F0F0, B=0x0FF00FF0, opcodes 0 to 7 back-to-back with out_ready=1 -> 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00, 0x000F000F, 0xFF0FFF0F, 0x00FF00FF, 0xF000F000, 0xF0FFF0FF, each 2 cycles after acceptance, one per cycle.
REQ-039 Directed scenario: opcode 9 with A=B=0xFFFFFFFF -> data_result=0, data_exception=1; a following opcode 1 -> data_exception=0.
REQ-040 Directed scenario: out_ready=0 while 3 transactions are offered -> 2 accepted, in_ready=0 on the third, outputs stable; then out_ready=1 -> all 3 delivered in order.
REQ-041 Directed scenario: reset_n pulsed low with 2 transactions in flight -> out_valid=0 asynchronously, no stale result appears after release.
REQ-042 Directed scenario: with BITWISE_REDUCE_EN defined, opcode 2 with A=B=0x12345678 -> data_isZero=1, data_parity=0; opcode 1 with A=0x7, B=0 -> data_isZero=0, data_parity=1.
